// File: rtl/sim_harness_ctrl.sv
// Simulation-harness controller: DUT reset sequencing, init/step handshakes, cycle limit and
// per-channel UART buffering drained round-robin. Define SIM_CTRL_STEP_TIMEOUT_EN for the watchdog.
module sim_harness_ctrl #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned CH_W          = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned RESET_HOLD    = 50,
    parameter int unsigned STEP_INTERVAL = 1,
    parameter int unsigned CYC_W         = 64,
    parameter int unsigned STEP_TIMEOUT  = 1024,
    localparam int unsigned CHAN_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   dut_reset,
    input  logic [CYC_W-1:0]       max_cycles,
    output logic                   init_req,
    input  logic                   init_ack,
    output logic                   step_req,
    input  logic                   step_rsp_valid,
    input  logic [7:0]             step_rsp_code,
    input  logic [NUM_CH-1:0]      uart_valid,
    input  logic [NUM_CH*CH_W-1:0] uart_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [CHAN_W-1:0]      out_chan,
    output logic [NUM_CH-1:0]      overflow,
    output logic [CYC_W-1:0]       cycle_cnt,
    output logic                   finish,
    output logic [7:0]             finish_code
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int unsigned PH_W   = $clog2(STEP_INTERVAL + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STEP_INTERVAL - 1);
    localparam logic [AW:0]       FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StHold, StInit, StWaitAck, StRun, StDone} state_e;

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PH_W-1:0]   phase;
    logic              step_pending;
    logic [CYC_W:0]    cyc_inc;
    logic              cyc_sat, max_hit, step_stop, step_free, timeout_hit;

    assign cyc_inc   = {1'b0, cycle_cnt} + {{CYC_W{1'b0}}, 1'b1};
    assign cyc_sat   = &cycle_cnt;
    assign max_hit   = (max_cycles != '0) && (cyc_inc >= {1'b0, max_cycles});
    assign step_stop = step_rsp_valid && (step_rsp_code != 8'd0);
    // A response arriving this cycle frees the slot for a request on the same edge.
    assign step_free = !step_pending || step_rsp_valid;

`ifdef SIM_CTRL_STEP_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(STEP_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    assign timeout_hit = step_pending && !step_rsp_valid && (wd_cnt == WD_W'(STEP_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset || state != StRun || !step_pending || step_rsp_valid) wd_cnt <= '0;
        else wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StHold;
            hold_cnt     <= '0;
            dut_reset    <= 1'b1;
            init_req     <= 1'b0;
            step_req     <= 1'b0;
            step_pending <= 1'b0;
            phase        <= '0;
            cycle_cnt    <= '0;
            finish       <= 1'b0;
            finish_code  <= 8'd0;
        end else begin
            init_req <= 1'b0;
            step_req <= 1'b0;
            if (step_rsp_valid) step_pending <= 1'b0;
            case (state)
                StHold: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= StInit;
                        dut_reset <= 1'b0;
                        init_req  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                StInit: state <= StWaitAck;
                StWaitAck: begin
                    if (init_ack) begin
                        state        <= StRun;
                        step_req     <= 1'b1;
                        step_pending <= 1'b1;
                        phase        <= '0;
                    end
                end
                StRun: begin
                    if (!cyc_sat) cycle_cnt <= cyc_inc[CYC_W-1:0];
                    if (step_stop) begin
                        state       <= StDone;
                        finish      <= 1'b1;
                        finish_code <= 8'd1;
                    end else if (max_hit) begin
                        state       <= StDone;
                        finish      <= 1'b1;
                        finish_code <= 8'd2;
                    end else if (timeout_hit) begin
                        state       <= StDone;
                        finish      <= 1'b1;
                        finish_code <= 8'd3;
                    end else if (phase == PH_LAST) begin
                        if (step_free) begin
                            step_req     <= 1'b1;
                            step_pending <= 1'b1;
                            phase        <= '0;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                StDone: ;
                default: state <= StHold;
            endcase
        end
    end

    // UART capture and per-channel FIFOs. The presented char stays in its FIFO until transferred.
    logic [NUM_CH-1:0]      cap_valid;
    logic [NUM_CH*CH_W-1:0] cap_ch;
    logic [CH_W-1:0]        mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr  [NUM_CH];
    logic [AW-1:0]          rd_ptr  [NUM_CH];
    logic [AW:0]            count   [NUM_CH];
    logic [AW-1:0]          eff_rd  [NUM_CH];
    logic [AW:0]            eff_cnt [NUM_CH];
    logic [NUM_CH-1:0]      push, pop, full;
    logic [CHAN_W-1:0]      last_grant, grant;
    logic                   grant_found, load;
    int unsigned            rr_idx;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]    = (count[i] == FULL_CNT);
            push[i]    = cap_valid[i] && !full[i];
            pop[i]     = out_valid && out_ready && (out_chan == CHAN_W'(i));
            eff_cnt[i] = count[i] - (AW + 1)'(pop[i]);
            eff_rd[i]  = rd_ptr[i] + AW'(pop[i]);
        end
        load        = !out_valid || out_ready;
        grant       = last_grant;
        grant_found = 1'b0;
        rr_idx      = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            rr_idx = (32'(last_grant) + k) % NUM_CH;
            if (!grant_found && eff_cnt[CHAN_W'(rr_idx)] != '0) begin
                grant       = CHAN_W'(rr_idx);
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_valid  <= '0;
            cap_ch     <= '0;
            overflow   <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_chan   <= '0;
            last_grant <= CHAN_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            cap_valid <= uart_valid & {NUM_CH{~dut_reset}};
            cap_ch    <= uart_ch;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_valid[i] && full[i]) overflow[i] <= 1'b1;
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                rd_ptr[i] <= eff_rd[i];
                count[i]  <= eff_cnt[i] + (AW + 1)'(push[i]);
            end
            if (load) begin
                out_valid <= grant_found;
                if (grant_found) begin
                    out_ch     <= mem[grant][eff_rd[grant]];
                    out_chan   <= grant;
                    last_grant <= grant;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= cap_ch[i*CH_W +: CH_W];
        end
    end

endmodule

// File: doc/sim_harness_ctrl.md
Name: sim_harness_ctrl

Overview:
- Synthesizable simulation-harness controller; replaces ad-hoc testbench sequencing logic.
- Sits between the harness clock/reset and SimTop, and faces the host-side DPI shim.
- Sequences DUT reset, runs the init handshake and periodic step handshakes, and enforces the max-cycle limit.
- Buffers NUM_CH DUT UART output channels into per-channel FIFOs, drained by one round-robin host port.

Parameters:
- NUM_CH, 2: number of UART output channels (one per core/uart).
- CH_W, 8: character width.
- FIFO_DEPTH, 16: entries per channel FIFO; power of two, >=2.
- RESET_HOLD, 50: cycles DUT reset stays high after harness reset deasserts.
- STEP_INTERVAL, 1: cycles between step requests in RUN; >=1.
- CYC_W, 64: width of cycle counter and max_cycles.
- STEP_TIMEOUT, 1024: step-response watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  harness clock
- reset  in  1  harness reset; synchronous, active-high
- dut_reset  out  1  reset to SimTop
- max_cycles  in  CYC_W  cycle limit; 0 = unlimited; sampled every cycle
- init_req  out  1  one-cycle init pulse to host
- init_ack  in  1  host finished init
- step_req  out  1  one-cycle step pulse
- step_rsp_valid  in  1  step result valid
- step_rsp_code  in  8  0 = continue, nonzero = stop
- uart_valid  in  NUM_CH  per-channel char valid from DUT
- uart_ch  in  NUM_CH*CH_W  packed chars; channel i at [i*CH_W +: CH_W]
- out_valid  out  1  buffered char available
- out_ready  in  1  host accepts char
- out_ch  out  CH_W  char
- out_chan  out  $clog2(NUM_CH) (min 1)  source channel
- overflow  out  NUM_CH  sticky per-channel drop flag
- cycle_cnt  out  CYC_W  cycles spent in RUN
- finish  out  1  sticky; simulation must end
- finish_code  out  8  reason: 1 = step stop (code in finish_code[7:1] is not used; see Behaviour), 2 = max cycles, 3 = step timeout

Behaviour:
- Reset values: dut_reset=1, init_req=0, step_req=0, out_valid=0, overflow=0, cycle_cnt=0, finish=0, finish_code=0; FIFOs empty; state=HOLD; hold counter=0.
- FSM states: HOLD, INIT, WAIT_ACK, RUN, DONE.
- HOLD: dut_reset=1. Counts RESET_HOLD cycles after reset falls, then goes to INIT and drops dut_reset on that same edge.
- INIT: init_req=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: waits indefinitely for init_ack=1, then RUN. init_ack in any other state is ignored.
- RUN: each cycle, cycle_cnt increments, saturating at all-ones.
  - A phase counter issues step_req for one cycle every STEP_INTERVAL cycles; the first step_req comes on the first RUN cycle.
  - No new step_req is issued while a step is outstanding (req sent, rsp not yet received); the phase counter holds meanwhile.
  - step_rsp_valid with nonzero code: DONE, finish_code=1.
  - max_cycles!=0 and cycle_cnt+1 >= max_cycles on an increment: DONE, finish_code=2.
  - If both happen in the same cycle, the step stop wins (code 1).
- DONE: finish=1, held until reset. step_req never asserts again. UART buffering and drain continue.
- UART capture: accepted in every state except while reset=1. Chars with dut_reset=1 are discarded.
  - A channel's char is written to its FIFO the cycle after uart_valid.
  - If that FIFO is full, including full-and-popped-same-cycle, the char is dropped and overflow[i] is set; the flag stays set until reset.
  - A simultaneous push and pop on a non-full FIFO are both performed.
- Drain: round-robin over non-empty FIFOs, starting after the last-granted channel; channel 0 is first after reset.
  - out_valid/out_ch/out_chan are registered and must stay stable while out_valid=1 && out_ready=0.
  - Transfer on out_valid&&out_ready. The next char may present the following cycle, so throughput is 1 char/cycle.
- Reset asserted in any state returns everything to reset values on the next edge; FIFO contents are lost.

Optional Feature:
- Macro: SIM_CTRL_STEP_TIMEOUT_EN.
- Defined: a watchdog counts cycles while a step is outstanding. When it reaches STEP_TIMEOUT, the block enters DONE with finish_code=3. The watchdog clears on step_rsp_valid.
- Undefined: no watchdog; an outstanding step waits forever; code 3 is never produced.

Test Plan:
- Release reset at cycle 0 with RESET_HOLD=50 -> dut_reset falls at cycle 50; init_req pulses once at cycle 50; no step_req before init_ack.
- init_ack at cycle 60, STEP_INTERVAL=4, host responds to each step_req 1 cycle later with code 0 -> step_req every 4 cycles; cycle_cnt=20 after 20 RUN cycles.
- max_cycles=100, steps always code 0 -> finish=1, finish_code=2 with cycle_cnt=100. Repeat with a code 5 response on that same cycle -> finish_code=1.
- Channels 0 and 1 each push "AB" in the same cycles, out_ready=1 -> out order A(0), A(1), B(0), B(1). Then hold out_ready=0 for 5 cycles -> out_ch stable.
- FIFO_DEPTH=16, out_ready=0, 18 chars on channel 0 -> 16 stored, overflow[0]=1, overflow[1]=0. Drain yields the first 16 chars in order.
- With SIM_CTRL_STEP_TIMEOUT_EN and STEP_TIMEOUT=8, no step_rsp -> finish_code=3 exactly 8 cycles after step_req. Without the macro -> finish stays 0 after 1000 cycles.
